// File: rtl/tagger_pkg.sv
// Shared definitions for the pulse tagger acquisition path: run-state
// encoding, record field positions and default widths.
package tagger_pkg;

   localparam int DEF_REC_W = 44;
   localparam int DEF_CNT_W = 32;

   // Record layout: {channel mask, wrap marker, timestamp}
   localparam int REC_CH_MSB   = 43;
   localparam int REC_CH_LSB   = 40;
   localparam int REC_WRAP_BIT = 39;
   localparam int REC_TS_MSB   = 38;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CLEARING = 2'd1,
      RUN      = 2'd2,
      DRAIN    = 2'd3
   } acqState_e;

endpackage

// File: rtl/tagger_sat_counter.sv
// Saturating up-counter with synchronous clear. Once it reaches all-ones
// it stays there, so a long run never shows a small count after wrapping.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;

   // Clear has priority over increment; increment stops at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/tagger_acq_ctrl.sv
// Acquisition run sequencer: clears the time-stamp timer, enables the
// registration block, captures records into a one-entry output register
// with a valid/accept handshake, and keeps record/wrap/lost counters.
module tagger_acq_ctrl
   import tagger_pkg::*;
#(
   parameter int REC_W   = DEF_REC_W,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int CLR_CYC = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_start,
   input  logic             cmd_stop,
   input  logic             cfg_limit_en,
   input  logic [CNT_W-1:0] cfg_limit,
   output logic             tag_clear,
   output logic             tag_operate,
   input  logic [REC_W-1:0] rec_data,
   input  logic             rec_ready,
   output logic [REC_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_accept,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] rec_count,
   output logic [CNT_W-1:0] wrap_count,
   output logic [CNT_W-1:0] lost_count
);

   localparam int               CLR_W    = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
   localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);

   acqState_e        state_q, state_d;
   logic [CLR_W-1:0] clrCnt_q, clrCnt_d;
   logic             tagClear_q, tagOperate_q, done_q;
   logic             outValid_q;
   logic [REC_W-1:0] outData_q;

   logic inRun, runStart, limitHit, capture, lose, xfer;

   assign inRun    = (state_q == RUN);
   assign runStart = (state_q == IDLE) && cmd_start;
   assign limitHit = cfg_limit_en && (rec_count >= cfg_limit);
   assign xfer     = outValid_q && out_accept;
   assign capture  = inRun && rec_ready && (!outValid_q || out_accept);
   assign lose     = inRun && rec_ready && outValid_q && !out_accept;

   // Next-state decode for the run sequence and the clear-phase cycle count.
   always_comb begin
      state_d  = state_q;
      clrCnt_d = clrCnt_q;
      case (state_q)
         IDLE: begin
            if (cmd_start) begin
               state_d  = CLEARING;
               clrCnt_d = '0;
            end
         end
         CLEARING: begin
            if (cmd_stop) begin
               state_d = DRAIN;
            end else if (clrCnt_q == CLR_LAST) begin
               state_d = RUN;
            end else begin
               clrCnt_d = clrCnt_q + 1'b1;
            end
         end
         RUN: begin
            if (cmd_stop || limitHit) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!outValid_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register plus registered control outputs decoded from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         clrCnt_q     <= '0;
         tagClear_q   <= 1'b1;
         tagOperate_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         clrCnt_q     <= clrCnt_d;
         tagClear_q   <= (state_d == IDLE) || (state_d == CLEARING);
         tagOperate_q <= (state_d == RUN);
         done_q       <= (state_q == DRAIN) && (state_d == IDLE);
      end
   end

   // One-entry output register; a new run discards whatever was still held.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         outValid_q <= 1'b0;
         outData_q  <= '0;
      end else if (runStart) begin
         outValid_q <= 1'b0;
      end else if (capture) begin
         outValid_q <= 1'b1;
         outData_q  <= rec_data;
      end else if (xfer) begin
         outValid_q <= 1'b0;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_recCnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (runStart),
      .inc_i   (capture),
      .count_o (rec_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_wrapCnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (runStart),
      .inc_i   (capture && rec_data[REC_WRAP_BIT]),
      .count_o (wrap_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_lostCnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (runStart),
      .inc_i   (lose),
      .count_o (lost_count)
   );

   assign tag_clear   = tagClear_q;
   assign tag_operate = tagOperate_q;
   assign done        = done_q;
   assign busy        = (state_q != IDLE);
   assign out_valid   = outValid_q;
   assign out_data    = outData_q;

endmodule

// File: tb/tb_tagger_acq_ctrl.sv
// Self-checking bench for tagger_acq_ctrl: scenario tasks with randomized
// record data, compared against a cycle-level reference model of the run rules.
module tb_tagger_acq_ctrl;
   import tagger_pkg::*;

   localparam int REC_W   = 44;
   localparam int CNT_W   = 32;
   localparam int CLR_CYC = 2;
   localparam int VEC_W   = 5 + REC_W + 3 * CNT_W;

   localparam int P_IDLE  = 0;
   localparam int P_CLR   = 1;
   localparam int P_RUN   = 2;
   localparam int P_DRAIN = 3;

   localparam longint MAXC = (longint'(1) << CNT_W) - 1;

   logic             clk          = 1'b0;
   logic             reset_n      = 1'b1;
   logic             cmd_start    = 1'b0;
   logic             cmd_stop     = 1'b0;
   logic             cfg_limit_en = 1'b0;
   logic [CNT_W-1:0] cfg_limit    = '0;
   logic [REC_W-1:0] rec_data     = '0;
   logic             rec_ready    = 1'b0;
   logic             out_accept   = 1'b0;
   logic             tag_clear, tag_operate, out_valid, busy, done;
   logic [REC_W-1:0] out_data;
   logic [CNT_W-1:0] rec_count, wrap_count, lost_count;

   int checks   = 0;
   int failures = 0;

   // Reference model of the run: phase, held record queue and counters
   int               mPhase;
   int               mClrLeft;
   logic [REC_W-1:0] mHeld[$];
   logic [REC_W-1:0] mOutData;
   longint           mRec, mWrap, mLost;
   bit               mDone;

   int               cycNum  = 0;
   int               vecErrs = 0;
   int               firstCyc;
   logic [VEC_W-1:0] firstObs, firstExp;

   always #5 clk = ~clk;

   tagger_acq_ctrl #(.REC_W(REC_W), .CNT_W(CNT_W), .CLR_CYC(CLR_CYC)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cmd_start    (cmd_start),
      .cmd_stop     (cmd_stop),
      .cfg_limit_en (cfg_limit_en),
      .cfg_limit    (cfg_limit),
      .tag_clear    (tag_clear),
      .tag_operate  (tag_operate),
      .rec_data     (rec_data),
      .rec_ready    (rec_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_accept   (out_accept),
      .busy         (busy),
      .done         (done),
      .rec_count    (rec_count),
      .wrap_count   (wrap_count),
      .lost_count   (lost_count)
   );

   function automatic logic [REC_W-1:0] randRec();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[REC_W-1:0];
   endfunction

   function automatic longint satInc(longint v);
      return (v >= MAXC) ? v : v + 1;
   endfunction

   function automatic logic [VEC_W-1:0] obsVec();
      return {tag_clear, tag_operate, busy, done, out_valid, out_data,
              rec_count, wrap_count, lost_count};
   endfunction

   function automatic logic [VEC_W-1:0] expVec();
      return {(mPhase == P_IDLE) || (mPhase == P_CLR), mPhase == P_RUN,
              mPhase != P_IDLE, mDone, mHeld.size() != 0, mOutData,
              CNT_W'(mRec), CNT_W'(mWrap), CNT_W'(mLost)};
   endfunction

   task automatic modelReset();
      mPhase   = P_IDLE;
      mClrLeft = 0;
      mHeld.delete();
      mOutData = '0;
      mRec     = 0;
      mWrap    = 0;
      mLost    = 0;
      mDone    = 1'b0;
   endtask

   // Advance the model by one clock using the inputs about to be sampled
   task automatic modelStep();
      bit     wasFull, hit;
      int     nextPhase;
      longint limV;
      limV      = 0;
      limV[CNT_W-1:0] = cfg_limit;
      wasFull   = (mHeld.size() != 0);
      hit       = cfg_limit_en && (mRec >= limV);
      nextPhase = mPhase;
      mDone     = 1'b0;
      case (mPhase)
         P_IDLE:  if (cmd_start) nextPhase = P_CLR;
         P_CLR: begin
            if (cmd_stop) nextPhase = P_DRAIN;
            else begin
               mClrLeft--;
               if (mClrLeft == 0) nextPhase = P_RUN;
            end
         end
         P_RUN:   if (cmd_stop || hit) nextPhase = P_DRAIN;
         default: if (!wasFull) begin nextPhase = P_IDLE; mDone = 1'b1; end
      endcase
      if (wasFull && out_accept) void'(mHeld.pop_front());
      if ((mPhase == P_RUN) && rec_ready) begin
         if (mHeld.size() == 0) begin
            mHeld.push_back(rec_data);
            mOutData = rec_data;
            mRec     = satInc(mRec);
            if (rec_data[REC_WRAP_BIT]) mWrap = satInc(mWrap);
         end else begin
            mLost = satInc(mLost);
         end
      end
      if ((mPhase == P_IDLE) && cmd_start) begin
         mRec     = 0;
         mWrap    = 0;
         mLost    = 0;
         mClrLeft = CLR_CYC;
         mHeld.delete();
      end
      mPhase = nextPhase;
   endtask

   // One clock: step the model, wait the edge, sample and trace-compare
   task automatic cycle();
      logic [VEC_W-1:0] o, e;
      modelStep();
      @(posedge clk);
      #1;
      cmd_start = 1'b0;
      cmd_stop  = 1'b0;
      rec_ready = 1'b0;
      cycNum++;
      o = obsVec();
      e = expVec();
      if (o !== e) begin
         if (vecErrs == 0) begin
            firstCyc = cycNum;
            firstObs = o;
            firstExp = e;
         end
         vecErrs++;
      end
   endtask

   task automatic startRun(output bit ok);
      ok = 1'b0;
      cmd_start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (tag_operate) begin ok = 1'b1; break; end
      end
   endtask

   task automatic stopRun(output int doneCnt, output bit ok);
      ok = 1'b0;
      doneCnt = 0;
      out_accept = 1'b1;
      cmd_stop = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (done) doneCnt++;
         if (!busy) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      logic [VEC_W-1:0] want;
      vecErrs = 0;
      #2 reset_n = 1'b0;
      modelReset();
      #1;
      want = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {REC_W{1'b0}}, {(3*CNT_W){1'b0}}};
      checks++;
      if (obsVec() !== want) begin
         failures++;
         $display("[TB] FAIL reset_values: got %h want %h", obsVec(), want);
      end
      @(negedge clk);
      reset_n = 1'b1;
      cycle();
      cycle();
      checks++;
      if (vecErrs != 0) begin
         failures++;
         $display("[TB] FAIL reset_trace: %0d cycles off, first cyc %0d got %h want %h", vecErrs, firstCyc, firstObs, firstExp);
      end
   endtask

   task automatic test_basic();
      int clrHigh = 0;
      int doneCnt;
      bit ok;
      logic [REC_W-1:0] d;
      vecErrs = 0;
      out_accept = 1'b1;
      cmd_start = 1'b1;
      for (int i = 0; i < CLR_CYC + 1; i++) begin
         cycle();
         if (tag_clear) clrHigh++;
      end
      checks++;
      if (clrHigh != CLR_CYC || tag_operate !== 1'b1) begin
         failures++;
         $display("[TB] FAIL basic_clear_phase: clear cycles %0d operate %b, want %0d and 1", clrHigh, tag_operate, CLR_CYC);
      end
      for (int i = 0; i < 3; i++) begin
         d = randRec();
         rec_ready = 1'b1;
         rec_data  = d;
         cycle();
         checks++;
         if (out_valid !== 1'b1 || out_data !== d) begin
            failures++;
            $display("[TB] FAIL basic_capture%0d: valid %b data %h, want 1 %h", i, out_valid, out_data, d);
         end
      end
      cmd_stop = 1'b1;
      cycle();
      checks++;
      if (tag_operate !== 1'b0) begin
         failures++;
         $display("[TB] FAIL basic_stop_operate: got %b want 0", tag_operate);
      end
      stopRun(doneCnt, ok);
      checks++;
      if (!ok || doneCnt != 1 || rec_count !== 32'd3 || lost_count !== 32'd0) begin
         failures++;
         $display("[TB] FAIL basic_end: idle %b done %0d rec %0d lost %0d, want 1 1 3 0", ok, doneCnt, rec_count, lost_count);
      end
      checks++;
      if (vecErrs != 0) begin
         failures++;
         $display("[TB] FAIL basic_trace: %0d cycles off, first cyc %0d got %h want %h", vecErrs, firstCyc, firstObs, firstExp);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int doneCnt;
      int xfers = 0;
      logic [REC_W-1:0] first, xData;
      vecErrs = 0;
      xData = '0;
      startRun(ok);
      out_accept = 1'b0;
      first = randRec();
      for (int i = 0; i < 4; i++) begin
         rec_ready = 1'b1;
         rec_data  = (i == 0) ? first : randRec();
         cycle();
      end
      cycle();
      checks++;
      if (!ok || rec_count !== 32'd1 || lost_count !== 32'd3 || out_data !== first) begin
         failures++;
         $display("[TB] FAIL bp_counts: run %b rec %0d lost %0d data %h, want 1 1 3 %h", ok, rec_count, lost_count, out_data, first);
      end
      out_accept = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (out_valid && out_accept) begin
            xfers++;
            xData = out_data;
         end
         cycle();
      end
      checks++;
      if (xfers != 1 || xData !== first) begin
         failures++;
         $display("[TB] FAIL bp_release: transfers %0d data %h, want 1 %h", xfers, xData, first);
      end
      stopRun(doneCnt, ok);
      checks++;
      if (vecErrs != 0 || !ok) begin
         failures++;
         $display("[TB] FAIL bp_trace: idle %b, %0d cycles off, first cyc %0d got %h want %h", ok, vecErrs, firstCyc, firstObs, firstExp);
      end
   endtask

   task automatic test_overlap();
      bit ok;
      int doneCnt;
      logic [REC_W-1:0] b;
      vecErrs = 0;
      startRun(ok);
      out_accept = 1'b0;
      rec_ready  = 1'b1;
      rec_data   = randRec();
      cycle();
      b = randRec();
      out_accept = 1'b1;
      rec_ready  = 1'b1;
      rec_data   = b;
      cycle();
      checks++;
      if (!ok || out_valid !== 1'b1 || out_data !== b) begin
         failures++;
         $display("[TB] FAIL overlap_data: run %b valid %b data %h, want 1 1 %h", ok, out_valid, out_data, b);
      end
      checks++;
      if (lost_count !== 32'd0 || rec_count !== 32'd2) begin
         failures++;
         $display("[TB] FAIL overlap_counts: lost %0d rec %0d, want 0 2", lost_count, rec_count);
      end
      stopRun(doneCnt, ok);
      checks++;
      if (vecErrs != 0 || !ok || doneCnt != 1) begin
         failures++;
         $display("[TB] FAIL overlap_trace: idle %b done %0d, %0d cycles off, first got %h want %h", ok, doneCnt, vecErrs, firstObs, firstExp);
      end
   endtask

   task automatic test_limit();
      bit ok, fell = 1'b0, idle = 1'b0;
      int doneCnt = 0;
      vecErrs = 0;
      cfg_limit_en = 1'b1;
      cfg_limit    = 32'd5;
      out_accept   = 1'b1;
      startRun(ok);
      for (int i = 0; i < 30; i++) begin
         rec_ready = 1'b1;
         rec_data  = randRec();
         cycle();
         if (!tag_operate) begin fell = 1'b1; break; end
      end
      checks++;
      if (!ok || !fell || rec_count < 32'd5 || rec_count > 32'd6) begin
         failures++;
         $display("[TB] FAIL limit_stop: run %b fell %b rec %0d, want 1 1 and 5..6", ok, fell, rec_count);
      end
      for (int i = 0; i < 10; i++) begin
         rec_ready = 1'b1;
         rec_data  = randRec();
         cycle();
         if (done) doneCnt++;
         if (!busy) begin idle = 1'b1; break; end
      end
      cfg_limit_en = 1'b0;
      checks++;
      if (!idle || doneCnt != 1 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL limit_drain: idle %b done %0d valid %b, want 1 1 0", idle, doneCnt, out_valid);
      end
      checks++;
      if (vecErrs != 0) begin
         failures++;
         $display("[TB] FAIL limit_trace: %0d cycles off, first cyc %0d got %h want %h", vecErrs, firstCyc, firstObs, firstExp);
      end
   endtask

   task automatic test_wrap_gating();
      bit ok;
      int doneCnt;
      logic [REC_W-1:0] w;
      vecErrs = 0;
      out_accept = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rec_ready = 1'b1;
         rec_data  = randRec();
         cycle();
      end
      checks++;
      if (rec_count !== CNT_W'(mRec) || lost_count !== CNT_W'(mLost) || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL gate_idle_hold: rec %0d lost %0d busy %b, want %0d %0d 0", rec_count, lost_count, busy, mRec, mLost);
      end
      cmd_start = 1'b1;
      for (int i = 0; i < CLR_CYC + 1; i++) begin
         rec_ready = 1'b1;
         rec_data  = randRec();
         cycle();
      end
      checks++;
      if (tag_operate !== 1'b1 || {rec_count, wrap_count, lost_count} !== '0) begin
         failures++;
         $display("[TB] FAIL gate_clearing: operate %b rec %0d wrap %0d lost %0d, want 1 0 0 0", tag_operate, rec_count, wrap_count, lost_count);
      end
      w = randRec();
      w[REC_CH_MSB:REC_CH_LSB] = '0;
      w[REC_WRAP_BIT] = 1'b1;
      rec_ready = 1'b1;
      rec_data  = w;
      cycle();
      checks++;
      if (wrap_count !== 32'd1 || rec_count !== 32'd1 || out_data !== w) begin
         failures++;
         $display("[TB] FAIL wrap_count: wrap %0d rec %0d data %h, want 1 1 %h", wrap_count, rec_count, out_data, w);
      end
      cmd_start = 1'b1;
      cycle();
      cycle();
      checks++;
      if (tag_operate !== 1'b1 || tag_clear !== 1'b0 || rec_count !== 32'd1 || wrap_count !== 32'd1) begin
         failures++;
         $display("[TB] FAIL start_in_run: operate %b clear %b rec %0d wrap %0d, want 1 0 1 1", tag_operate, tag_clear, rec_count, wrap_count);
      end
      stopRun(doneCnt, ok);
      checks++;
      if (vecErrs != 0 || !ok) begin
         failures++;
         $display("[TB] FAIL gate_trace: idle %b, %0d cycles off, first cyc %0d got %h want %h", ok, vecErrs, firstCyc, firstObs, firstExp);
      end
   endtask

   task automatic test_random();
      bit ok;
      int doneCnt;
      vecErrs = 0;
      for (int i = 0; i < 1500; i++) begin
         if (i % 150 == 0) begin
            cfg_limit_en = ($urandom_range(0, 1) == 1);
            cfg_limit    = CNT_W'($urandom_range(0, 12));
         end
         cmd_start  = ($urandom_range(0, 15) == 0);
         cmd_stop   = ($urandom_range(0, 39) == 0);
         rec_ready  = ($urandom_range(0, 1) == 1);
         rec_data   = randRec();
         out_accept = ($urandom_range(0, 3) != 0);
         cycle();
      end
      cfg_limit_en = 1'b0;
      stopRun(doneCnt, ok);
      checks++;
      if (vecErrs != 0 || !ok) begin
         failures++;
         $display("[TB] FAIL random_trace: idle %b done %0d, %0d cycles off, first cyc %0d got %h want %h", ok, doneCnt, vecErrs, firstCyc, firstObs, firstExp);
      end
   endtask

   task automatic test_reset_midrun();
      bit ok;
      logic [VEC_W-1:0] want;
      vecErrs = 0;
      startRun(ok);
      out_accept = 1'b0;
      rec_ready  = 1'b1;
      rec_data   = randRec();
      cycle();
      checks++;
      if (!ok || out_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midrun_setup: run %b valid %b, want 1 1", ok, out_valid);
      end
      reset_n = 1'b0;
      modelReset();
      #1;
      want = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {REC_W{1'b0}}, {(3*CNT_W){1'b0}}};
      checks++;
      if (obsVec() !== want) begin
         failures++;
         $display("[TB] FAIL midrun_async_reset: got %h want %h", obsVec(), want);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cycle();
      startRun(ok);
      checks++;
      if (vecErrs != 0 || !ok) begin
         failures++;
         $display("[TB] FAIL midrun_trace: restart %b, %0d cycles off, first cyc %0d got %h want %h", ok, vecErrs, firstCyc, firstObs, firstExp);
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      modelReset();
      test_reset();
      test_basic();
      test_backpressure();
      test_overlap();
      test_limit();
      test_wrap_gating();
      test_random();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
